onehot_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one output channel among CHANNELS valid/ready requesters.

---
 rtl/onehot_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_onehot_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: round-robin valid/ready arbiter with a one-hot grant,
// an AND-OR data mux and one registered output stage.
// Optional feature macro: ARB_PACKET_LOCK_EN (hold the grant until i_last).
module onehot_rr_arbiter #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       i_valid,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
`ifdef ARB_PACKET_LOCK_EN
    input  logic [CHANNELS-1:0]       i_last,
`endif
    output logic [CHANNELS-1:0]       i_ready,
    output logic                      o_valid,
    output logic [WIDTH-1:0]          o_data,
    output logic [CHANNELS-1:0]       o_grant,
    input  logic                      o_ready
);

    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(CHANNELS - 1);

    logic [PW-1:0]       ptr_q, ptr_d;
    logic                o_valid_q, o_valid_d;
    logic [WIDTH-1:0]    o_data_q, o_data_d;
    logic [CHANNELS-1:0] o_grant_q, o_grant_d;

    logic                load;
    logic [CHANNELS-1:0] hi_mask;
    logic [CHANNELS-1:0] req_hi;
    logic [CHANNELS-1:0] gnt_rr;
    logic [CHANNELS-1:0] gnt;
    logic [PW-1:0]       gnt_idx;
    logic [PW-1:0]       ptr_adv;
    logic [WIDTH-1:0]    mux_data;

    // Lowest set bit of a request vector, as a one-hot vector.
    function automatic logic [CHANNELS-1:0] first_set(
        input logic [CHANNELS-1:0] v
    );
        logic [CHANNELS-1:0] r;
        logic                seen;
        r    = '0;
        seen = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (v[k] && !seen) begin
                r[k] = 1'b1;
                seen = 1'b1;
            end
        end
        return r;
    endfunction

    // Binary index of a one-hot vector (zero when the vector is zero).
    function automatic logic [PW-1:0] onehot_to_idx(
        input logic [CHANNELS-1:0] oh
    );
        logic [PW-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (oh[k]) r = r | PW'(k);
        end
        return r;
    endfunction

    // Channels at or above the pointer are searched first, then the wrap.
    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            hi_mask[k] = (PW'(k) >= ptr_q);
        end
    end

    assign req_hi = i_valid & hi_mask;
    assign gnt_rr = (|req_hi) ? first_set(req_hi) : first_set(i_valid);

`ifdef ARB_PACKET_LOCK_EN
    logic                lock_q, lock_d;
    logic [CHANNELS-1:0] ptr_oh;
    logic                gnt_last;

    // Decode the frozen pointer so a locked packet keeps its channel.
    always_comb begin
        ptr_oh = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            ptr_oh[k] = (PW'(k) == ptr_q);
        end
    end

    assign gnt      = lock_q ? (i_valid & ptr_oh) : gnt_rr;
    assign gnt_last = |(i_last & gnt);
`else
    assign gnt = gnt_rr;
`endif

    assign load    = ~o_valid_q | o_ready;
    assign i_ready = gnt & {CHANNELS{load & rst_n}};
    assign gnt_idx = onehot_to_idx(gnt);
    assign ptr_adv = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

    // AND-OR one-hot mux of the granted word.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            mux_data = mux_data
                     | (i_data[k*WIDTH +: WIDTH] & {WIDTH{gnt[k]}});
        end
    end

    // Next state: refill on a grant, drain when nothing is granted.
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_grant_d = o_grant_q;
        ptr_d     = ptr_q;
`ifdef ARB_PACKET_LOCK_EN
        lock_d    = lock_q;
`endif
        if (load) begin
            o_valid_d = |gnt;
            if (|gnt) begin
                o_data_d  = mux_data;
                o_grant_d = gnt;
                ptr_d     = ptr_adv;
`ifdef ARB_PACKET_LOCK_EN
                if (!gnt_last) begin
                    lock_d = 1'b1;
                    ptr_d  = gnt_idx;
                end else begin
                    lock_d = 1'b0;
                end
`endif
            end
        end
    end

    // Output stage and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_grant_q <= '0;
            ptr_q     <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_grant_q <= o_grant_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef ARB_PACKET_LOCK_EN
    // Packet lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_grant = o_grant_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: scoreboard bench for onehot_rr_arbiter
// with CHANNELS=4, WIDTH=8; directed cases followed by random traffic.
module tb_onehot_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   i_valid;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_ready;
    logic           o_valid;
    logic [W-1:0]   o_data;
    logic [N-1:0]   o_grant;
    logic           o_ready;
`ifdef ARB_PACKET_LOCK_EN
    logic [N-1:0]   i_last;
`endif

    onehot_rr_arbiter #(.CHANNELS(N), .WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_data  (i_data),
`ifdef ARB_PACKET_LOCK_EN
        .i_last  (i_last),
`endif
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_grant (o_grant),
        .o_ready (o_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic [N-1:0] g;
    } word_t;

    int     total = 0;
    int     bad   = 0;
    word_t  exp_q[$];

    // reference model state
    int     m_ptr  = 0;
    bit     m_ov   = 0;
    bit     m_lock = 0;

    bit           fire_seen = 0;
    logic [N-1:0] dut_rdy;
    int           xfer_g;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Which channel the rules select for this request vector (-1: none).
    function automatic int pick(input logic [N-1:0] v);
        if (m_lock) return v[m_ptr] ? m_ptr : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic advance(input int g, input logic last);
`ifdef ARB_PACKET_LOCK_EN
        if (!last) begin
            m_lock = 1;
            m_ptr  = g;
            return;
        end
        m_lock = 0;
`endif
        m_ptr = (g + 1) % N;
    endtask

    // One cycle of stimulus; predicted words go to the scoreboard.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic ordy, input logic [N-1:0] l);
        bit           ld;
        int           g;
        logic [N-1:0] oh;
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        o_ready = ordy;
`ifdef ARB_PACKET_LOCK_EN
        i_last  = l;
`endif
        #1;
        ld = !m_ov || ordy;
        g  = ld ? pick(v) : -1;
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        chk("o_valid", o_valid, m_ov);
        chk("i_ready", i_ready, oh);
        dut_rdy   = i_ready;
        fire_seen = |(i_valid & i_ready);
        xfer_g    = g;
        if (g >= 0) begin
            exp_q.push_back(word_t'{d: d[g*W +: W], g: oh});
            m_ov = 1;
            advance(g, l[g]);
        end else if (ld) begin
            m_ov = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        fire_seen = 0;
        m_ptr     = 0;
        m_ov      = 0;
        m_lock    = 0;
        exp_q.delete();
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_grant", o_grant, 0);
        chk("rst_i_ready", i_ready, 0);
        @(negedge clk);
        i_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: a new word appears after each observed handshake.
    word_t cur;
    bit    cur_ok = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            cur_ok = 0;
        end else begin
            if (fire_seen) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop: unexpected word got=%0h want=none",
                             o_data);
                end else begin
                    cur    = exp_q.pop_front();
                    cur_ok = 1;
                end
            end
            if (o_valid && cur_ok) begin
                chk("o_data", o_data, cur.d);
                chk("o_grant", o_grant, cur.g);
            end
        end
    end

    logic [N*W-1:0] dd;
    logic [N-1:0]   rv;
    logic [N*W-1:0] rd;
    logic [N-1:0]   rl;
    logic [W-1:0]   held;

    initial begin
        dd      = {8'h44, 8'h33, 8'h22, 8'h11};
        rst_n   = 1'b0;
        i_valid = '1;
        i_data  = dd;
        o_ready = 1'b1;
`ifdef ARB_PACKET_LOCK_EN
        i_last  = '1;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("init_o_valid", o_valid, 0);
        chk("init_o_data", o_data, 0);
        chk("init_o_grant", o_grant, 0);
        chk("init_i_ready", i_ready, 0);
        i_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // all channels requesting: strict rotation
        for (int k = 0; k < 8; k++) begin
            step('1, dd, 1'b1, '1);
            chk("rot_gnt", dut_rdy, 32'(1 << (k % 4)));
            if (k > 0) chk("rot_o_valid", o_valid, 1);
        end

        // reset while a word is held
        do_reset();

        // single requester
        step(4'b0100, {8'h00, 8'hC3, 8'h00, 8'h00}, 1'b1, '1);
        chk("single_rdy", dut_rdy, 4'b0100);
        step('0, dd, 1'b1, '1);
        chk("single_o_valid", o_valid, 1);
        chk("single_o_data", o_data, 8'hC3);
        chk("single_o_grant", o_grant, 4'b0100);

        // wrap from channel 3 to channel 0, pointer ends at 1
        step(4'b1001, dd, 1'b1, '1);
        chk("wrap_ch3", dut_rdy, 4'b1000);
        step(4'b1001, dd, 1'b1, '1);
        chk("wrap_ch0", dut_rdy, 4'b0001);
        step('1, dd, 1'b1, '1);
        chk("wrap_ptr1", dut_rdy, 4'b0010);

        // backpressure then refill in the same cycle
        step('1, dd, 1'b0, '1);
        held = o_data;
        for (int k = 0; k < 3; k++) begin
            step('1, dd, 1'b0, '1);
            chk("bp_rdy", dut_rdy, 0);
            chk("bp_hold", o_data, held);
        end
        step('1, dd, 1'b1, '1);
        chk("bp_refill", $countones(dut_rdy), 1);

        // packet beats from channel 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step('1, dd, 1'b1, (k < 2) ? 4'b1110 : 4'b1111);
`ifdef ARB_PACKET_LOCK_EN
            chk("pkt_gnt", dut_rdy, (k < 3) ? 4'b0001 : 4'b0010);
`else
            chk("pkt_gnt", dut_rdy, 32'(1 << k));
`endif
        end

        // random traffic; waiting requests keep their word stable
        rv = '0;
        rd = '0;
        rl = '1;
        xfer_g = -1;
        repeat (400) begin
            for (int k = 0; k < N; k++) begin
                if (!rv[k] || xfer_g == k) begin
                    rv[k]          = ($urandom_range(0, 2) != 0);
                    rd[k*W +: W]   = W'($urandom);
                    rl[k]          = ($urandom_range(0, 2) == 0);
                end
            end
            step(rv, rd, ($urandom_range(0, 3) != 0), rl);
        end

        repeat (3) step('0, rd, 1'b1, '1);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
